// File: rtl/serial_ripple_subtractor.sv
// Bit-serial WIDTH-bit subtractor (out = in0 - in1, bout = borrow), LSB first, one bit per clock.
// Optional signed overflow output ovf enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Single full-subtractor cell working on the current LSBs.
    logic diff_bit;
    logic borrow_nxt;
    assign diff_bit   = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = in0;
                    b_d      = in1;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    a_msb_d  = in0[WIDTH-1];
                    b_msb_d  = in1[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                res_d    = {diff_bit, res_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // Last diff_bit is the result MSB.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (diff_bit ^ a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign out  = out_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed handshake/reset steps plus random and exhaustive operands.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, modulo 2^W, borrow = unsigned less-than.
    function automatic logic [W-1:0] ref_diff(input int a, input int b);
        return W'((a - b + (1 << W)) % (1 << W));
    endfunction

    function automatic logic ref_borrow(input int a, input int b);
        return (a < b) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic ref_ovf(input int a, input int b);
        int sa, sb, sd;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd = sa - sb;
        return ((sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)))) ? 1'b1 : 1'b0;
    endfunction

    task automatic run_op(input int a, input int b, input string tag);
        int cnt;
        @(negedge clk);
        in0   = W'(a);
        in1   = W'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_hi"}, busy, 1);
        cnt = 0;
        while (done !== 1'b1 && cnt < 4 * W) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ".latency"}, cnt, W);
        check({tag, ".busy_lo"}, busy, 0);
        check({tag, ".out"}, out, ref_diff(a, b));
        check({tag, ".bout"}, bout, ref_borrow(a, b));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, ".ovf"}, ovf, ref_ovf(a, b));
`endif
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".out_hold"}, out, ref_diff(a, b));
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (done !== 1'b1 && cnt < 40);
    endtask

    initial begin
        int pulses;
        int cnt;

        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.out", out, 0);
        check("rst.bout", bout, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("rst.ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        run_op(5, 3, "basic");
        run_op(3, 5, "borrow1");
        run_op(0, 1, "borrow2");
        run_op(0, 0, "zero");
        run_op(7, 8, "ovf1");
        run_op(6, 1, "ovf0");

        // Stray start two cycles into an operation must be ignored.
        @(negedge clk);
        in0 = 4'h5; in1 = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        in0 = 4'hF; in1 = 4'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                check("hs.out", out, 2);
            end
        end
        check("hs.pulses", pulses, 1);

        // start held high: one result every W+2 cycles.
        @(negedge clk);
        in0 = 4'h9; in1 = 4'h4; start = 1'b1;
        wait_done(cnt);
        check("held.first", cnt, W + 1);
        repeat (3) begin
            wait_done(cnt);
            check("held.period", cnt, W + 2);
            check("held.out", out, 5);
        end
        start = 1'b0;

        // Reset at counter=2 discards the operation.
        @(negedge clk);
        in0 = 4'h3; in1 = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid.busy", busy, 0);
        check("mid.done", done, 0);
        check("mid.out", out, 0);
        check("mid.bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("mid.no_done", pulses, 0);
        run_op(9, 4, "post_rst");

        repeat (40) run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)), "rand");

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(a, b, "sweep");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial N-bit subtractor: computes out = in0 - in1 and produces a borrow-out, the inverse operation of the team's combinational ripple carry adder.
- Uses one full-subtractor cell, a borrow flop and a bit counter, processing one bit per clock, LSB first, under a start/busy/done handshake.
- Serves as the area-light arithmetic stage for the datapath.
- Also acts as the cross-check model for the adder bench: (a + b) - b = a.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a subtraction; sampled only in IDLE
- in0  input  WIDTH  minuend; captured on the accepting edge
- in1  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; out/bout valid from this cycle
- out  output  WIDTH  difference (in0 - in1) mod 2^WIDTH
- bout  output  1  final borrow; 1 when in0 < in1 unsigned

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, out=0, bout=0, internal shift registers=0, borrow=0, counter=0.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - On a rising edge with start=1, capture in0/in1 into shift registers A/B, clear borrow and counter, and go to SHIFT.
  - busy becomes 1 on that edge.
  - With start=0, hold.
- SHIFT, on each edge:
  - Compute one bit: d = a0 ^ b0 ^ borrow; borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - Shift d into the result register from the MSB side; shift A and B right by one.
  - Increment the counter.
  - On the edge where counter = WIDTH-1, go to DONE, load out with the completed result and bout with borrow_next, and set busy=0.
- DONE:
  - done=1 for exactly this one cycle, then unconditionally go to IDLE.
  - start is ignored in DONE.
- Latency: done rises on the WIDTH-th rising edge after the edge that accepted start (WIDTH=4 gives 4 edges). Back-to-back throughput is one result per WIDTH+2 cycles.
- out and bout change only on the edge entering DONE and hold their values until the next operation's DONE.
- start asserted while busy=1 or in DONE: ignored, with no side effect. in0/in1 changes during SHIFT have no effect.
- Wrap-around: the result is modulo 2^WIDTH. For example, 0 - 1 gives all-ones with bout=1.
- Reset mid-operation: asserting rst_n low at any point immediately forces all reset values. The partial result is discarded and no done pulse occurs.
- start held high continuously: a new operation is accepted on the first IDLE edge after each DONE.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is loaded on the edge entering DONE with the two's-complement overflow flag: in0[MSB] != in1[MSB] and out[MSB] != in0[MSB], computed from the captured operands.
  - ovf holds alongside out.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic: WIDTH=4, in0=0101, in1=0011, start pulse. Expect busy high for 4 cycles, then done=1 for one cycle with out=0010, bout=0.
- Borrow: in0=0011, in1=0101. Expect out=1110, bout=1. Then in0=0000, in1=0001: expect out=1111, bout=1. Then 0000-0000: expect out=0000, bout=0.
- Handshake: pulse start again two cycles into an operation with in0=1111, in1=0001. Expect it ignored: out equals the first operation's result and only one done pulse occurs. Hold start high across several operations: expect a done pulse every 6 cycles.
- Reset mid-operation: assert rst_n=0 at counter=2. Expect busy=0, done=0, out=0, bout=0 asynchronously with no done pulse. After release, 1001-0100 gives out=0101, bout=0.
- Overflow (macro defined): in0=0111, in1=1000. Expect out=1111, bout=1, ovf=1. Then 0110-0001: expect out=0101, ovf=0.
- Exhaustive WIDTH=4 sweep, all 256 operand pairs: expect out == (in0-in1)&4'hF and bout == (in0<in1) for every pair, compared against a reference model.
